// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage: shift-add multiplier and restoring divider.
// Optional build macro MULDIV_EARLY_OUT_EN ends a multiply once the remaining multiplier bits are all zero.
module execute_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            DD_valid_i,
    input  logic [2:0]      DD_md_op_i,
    input  logic [XLEN-1:0] DD_rs1_data_i,
    input  logic [XLEN-1:0] DD_rs2_data_i,
    input  logic            E_flush_i,
    input  logic            E_hold_i,
    output logic            E_stall_o,
    output logic            E_md_valid_o,
    output logic [XLEN-1:0] E_md_res_o
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    state_t              state;
    state_t              next_state;
    logic [5:0]          count;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     opb;
    logic [2:0]          op;
    logic                neg_res;

    logic [2:0]          op_in;
    logic                rs1_neg;
    logic                rs2_neg;
    logic                sign_in;
    logic [XLEN-1:0]     mag1;
    logic [XLEN-1:0]     mag2;
    logic                div_zero;
    logic                div_ovf;
    logic                special;
    logic                mul_zero;
    logic                accept;
    logic [XLEN-1:0]     sp_quo;
    logic [XLEN-1:0]     sp_rem;

    assign op_in   = DD_md_op_i;
    assign rs1_neg = DD_rs1_data_i[XLEN-1] &
                     (op_in != OP_MULHU) & (op_in != OP_DIVU) & (op_in != OP_REMU);
    assign rs2_neg = DD_rs2_data_i[XLEN-1] &
                     ((op_in == OP_MUL) | (op_in == OP_MULH) | (op_in == OP_DIV) | (op_in == OP_REM));
    assign mag1    = cond_neg(DD_rs1_data_i, rs1_neg);
    assign mag2    = cond_neg(DD_rs2_data_i, rs2_neg);
    assign sign_in = ((op_in == OP_REM) | (op_in == OP_REMU)) ? rs1_neg : (rs1_neg ^ rs2_neg);

    // Divide corner cases bypass the iteration with a preloaded {remainder, quotient}
    assign div_zero = op_in[2] & (DD_rs2_data_i == '0);
    assign div_ovf  = ((op_in == OP_DIV) | (op_in == OP_REM)) &
                      (DD_rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) & (DD_rs2_data_i == '1);
    assign special  = div_zero | div_ovf;
    assign sp_quo   = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
    assign sp_rem   = div_zero ? DD_rs1_data_i : '0;
    assign accept   = (state == IDLE) & DD_valid_i & ~E_flush_i;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       rem_sh;
    logic [XLEN:0]       diff;
    logic                fits;
    logic [2*XLEN-1:0]   div_next;
    logic                calc_last;

    // Accumulator holds {product high, multiplier} or {remainder, quotient}
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, acc[XLEN-1:1]};
    assign rem_sh   = acc[2*XLEN-1:XLEN-1];
    assign diff     = rem_sh - {1'b0, opb};
    assign fits     = rem_sh[XLEN] | ~diff[XLEN];
    assign div_next = fits ? {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};

`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0] live_mask;
    assign live_mask = ~({XLEN{1'b1}} << count);
    assign calc_last = (count == 6'd0) | (~op[2] & ((acc[XLEN-1:0] & live_mask) == '0));
    assign mul_zero  = ~op_in[2] & (mag2 == '0);
`else
    assign calc_last = (count == 6'd0);
    assign mul_zero  = 1'b0;
`endif

    logic [2*XLEN-1:0]   prod_f;
    logic [XLEN-1:0]     quo_f;
    logic [XLEN-1:0]     rem_f;
    logic [XLEN-1:0]     fix_res;

    assign prod_f = cond_neg_wide(acc, neg_res);
    assign quo_f  = cond_neg(acc[XLEN-1:0], neg_res);
    assign rem_f  = cond_neg(acc[2*XLEN-1:XLEN], neg_res);

    always_comb begin
        fix_res = rem_f;
        case (op)
            OP_MUL:                       fix_res = prod_f[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_f[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res = quo_f;
            default:                      fix_res = rem_f;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (E_flush_i) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (DD_valid_i) next_state = (special | mul_zero) ? FIXUP : CALC;
                CALC:    if (calc_last) next_state = FIXUP;
                FIXUP:   next_state = DONE;
                DONE:    if (!E_hold_i) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        E_stall_o = (DD_valid_i & (state != DONE)) | ((state == DONE) & E_hold_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= 6'd0;
            acc     <= '0;
            opb     <= '0;
            op      <= 3'd0;
            neg_res <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op    <= op_in;
                        count <= 6'd32;
                        opb   <= op_in[2] ? mag2 : mag1;
                        if (special) begin
                            acc     <= {sp_rem, sp_quo};
                            neg_res <= 1'b0;
                        end else begin
                            acc     <= {{XLEN{1'b0}}, (op_in[2] ? mag1 : mag2)};
                            neg_res <= sign_in;
                        end
                    end
                end
                CALC: begin
                    if (!E_flush_i) begin
                        if (!calc_last) begin
                            acc   <= op[2] ? div_next : mul_next;
                            count <= count - 6'd1;
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        // Skipped iterations would only shift in zeros
                        else begin
                            acc <= acc >> count;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            E_md_valid_o <= 1'b0;
            E_md_res_o   <= '0;
        end else if (E_flush_i) begin
            E_md_valid_o <= 1'b0;
        end else if (state == FIXUP) begin
            E_md_valid_o <= 1'b1;
            E_md_res_o   <= fix_res;
        end else if ((state == DONE) && !E_hold_i) begin
            E_md_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed plus randomized bench for execute_muldiv against an arithmetic reference model.
module tb_execute_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        DD_valid_i = 1'b0;
    logic [2:0]  DD_md_op_i = 3'd0;
    logic [31:0] DD_rs1_data_i = 32'd0;
    logic [31:0] DD_rs2_data_i = 32'd0;
    logic        E_flush_i = 1'b0;
    logic        E_hold_i = 1'b0;
    logic        E_stall_o;
    logic        E_md_valid_o;
    logic [31:0] E_md_res_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = 32'd0;

    execute_muldiv #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .DD_valid_i    (DD_valid_i),
        .DD_md_op_i    (DD_md_op_i),
        .DD_rs1_data_i (DD_rs1_data_i),
        .DD_rs2_data_i (DD_rs2_data_i),
        .E_flush_i     (E_flush_i),
        .E_hold_i      (E_hold_i),
        .E_stall_o     (E_stall_o),
        .E_md_valid_o  (E_md_valid_o),
        .E_md_res_o    (E_md_res_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // RV32M semantics computed with native 64-bit and 32-bit arithmetic
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        int          ia;
        int          ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        ia = a;
        ib = b;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Edges from accept to the edge after which the result is valid
    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2]) begin
            if (b == 32'd0) return 1;
            if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 34;
        end
`ifdef MULDIV_EARLY_OUT_EN
        begin
            logic [31:0] m;
            int          n;
            m = ((op == 3'd0 || op == 3'd1) && b[31]) ? (~b + 32'd1) : b;
            if (m == 32'd0) return 1;
            n = 0;
            for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
            return 2 + n;
        end
`else
        return 34;
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 20);
            4:       return ~32'($urandom_range(0, 20)) + 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        DD_md_op_i    = op;
        DD_rs1_data_i = a;
        DD_rs2_data_i = b;
        DD_valid_i    = 1'b1;
    endtask

    task automatic wait_valid(output int lat, output bit busy_ok);
        bit found;
        found   = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (!found && lat < 60) begin
            @(posedge clk);
            @(negedge clk);
            if (E_md_valid_o === 1'b1) found = 1'b1;
            else begin
                if (E_stall_o !== 1'b1) busy_ok = 1'b0;
                lat++;
            end
        end
    endtask

    // Called at a negedge with the unit idle; returns at a negedge with the unit idle
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold_n);
        int          lat;
        bit          busy_ok;
        bit          stable;
        logic [31:0] exp;
        exp = ref_res(op, a, b);
        drive(op, a, b);
        #1 chk("stall_accept", 32'(E_stall_o), 32'd1);
        wait_valid(lat, busy_ok);
        chk($sformatf("latency op%0d", op), 32'(lat), 32'(exp_lat(op, a, b)));
        chk("busy_stall", 32'(busy_ok), 32'd1);
        chk($sformatf("result op%0d %08h,%08h", op, a, b), E_md_res_o, exp);
        E_hold_i = (hold_n > 0);
        #1 chk("done_stall", 32'(E_stall_o), 32'(hold_n > 0));
        stable = 1'b1;
        for (int i = 0; i < hold_n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (E_md_valid_o !== 1'b1 || E_md_res_o !== exp) stable = 1'b0;
        end
        if (hold_n > 0) chk("hold_stable", 32'(stable), 32'd1);
        E_hold_i   = 1'b0;
        DD_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("valid_clear", 32'(E_md_valid_o), 32'd0);
        last_res = exp;
    endtask

    task automatic expect_no_valid(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (E_md_valid_o === 1'b1) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int          lat;
        bit          busy_ok;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;

        // Reset behaviour
        DD_valid_i = 1'b1;
        #2;
        chk("rst_stall_follows_valid_hi", 32'(E_stall_o), 32'd1);
        chk("rst_valid", 32'(E_md_valid_o), 32'd0);
        chk("rst_res", E_md_res_o, 32'd0);
        DD_valid_i = 1'b0;
        #1 chk("rst_stall_follows_valid_lo", 32'(E_stall_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed arithmetic cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd5, 32'd100, 32'd7, 0);
        run_op(3'd7, 32'd100, 32'd7, 0);
        run_op(3'd5, 32'd5, 32'd0, 0);
        run_op(3'd6, 32'd5, 32'd0, 2);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd0, 32'd5, 32'd3, 0);

        // Flush during CALC: no result, unit returns to idle
        drive(3'd5, $urandom, 32'($urandom_range(1, 1000)));
        repeat (11) @(posedge clk);
        @(negedge clk);
        E_flush_i  = 1'b1;
        DD_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        E_flush_i = 1'b0;
        chk("flush_calc_valid", 32'(E_md_valid_o), 32'd0);
        expect_no_valid("flush_calc_no_pulse", 40);
        chk("flush_calc_res_kept", E_md_res_o, last_res);
        run_op(3'd5, 32'd9, 32'd3, 0);

        // Asynchronous reset mid-operation
        drive(3'd0, $urandom, $urandom);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(E_md_valid_o), 32'd0);
        chk("midrst_res", E_md_res_o, 32'd0);
        chk("midrst_stall", 32'(E_stall_o), 32'd1);
        @(negedge clk);
        rst        = 1'b0;
        DD_valid_i = 1'b0;
        expect_no_valid("midrst_no_result", 40);
        last_res = 32'd0;

        // Flush in IDLE blocks the accept on that edge
        drive(3'd7, 32'd1000, 32'd13);
        E_flush_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        E_flush_i = 1'b0;
        chk("flush_idle_valid", 32'(E_md_valid_o), 32'd0);
        run_op(3'd7, 32'd1000, 32'd13, 0);

        // Flush beats hold in DONE; result register is left alone
        a   = $urandom;
        b   = 32'($urandom_range(1, 50000));
        exp = ref_res(3'd5, a, b);
        drive(3'd5, a, b);
        wait_valid(lat, busy_ok);
        chk("flush_done_latency", 32'(lat), 32'd34);
        chk("flush_done_result", E_md_res_o, exp);
        E_hold_i  = 1'b1;
        E_flush_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        E_hold_i   = 1'b0;
        E_flush_i  = 1'b0;
        DD_valid_i = 1'b0;
        chk("flush_done_valid", 32'(E_md_valid_o), 32'd0);
        chk("flush_done_res_kept", E_md_res_o, exp);
        expect_no_valid("flush_done_idle", 3);

        // Randomized operations
        for (int n = 0; n < 24; n++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
